// File: rtl/axa_undo_pkg.sv
// Shared definitions for the register undo stack.
// Default sizes, FSM encoding and the saved-register record.
package axa_undo_pkg;

    localparam int DEPTH_DEF = 16;
    localparam int DW_DEF    = 16;
    localparam int RW_DEF    = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UNWIND = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef struct packed {
        logic [RW_DEF-1:0] rg;
        logic [DW_DEF-1:0] data;
    } rec_t;

    function automatic rec_t mk_rec(logic [RW_DEF-1:0] r,
                                    logic [DW_DEF-1:0] d);
        rec_t t;
        t.rg   = r;
        t.data = d;
        return t;
    endfunction

endpackage

// File: rtl/undo_lifo_mem.sv
// Undo-record storage: one synchronous write port,
// one asynchronous read port; contents are not reset.
module undo_lifo_mem #(
    parameter int DEPTH = 16,
    parameter int W     = 20
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    // write the saved record on an accepted push
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/undo_stack_ctrl.sv
// Undo stack controller: saves overwritten registers and
// replays them newest-first on an unwind request.
module undo_stack_ctrl
    import axa_undo_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int DW    = DW_DEF,
    parameter int RW    = RW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_valid,
    input  logic [RW-1:0] push_reg,
    input  logic [DW-1:0] push_data,
    output logic          push_ready,
    input  logic          unwind_req,
    input  logic [4:0]    unwind_n,
    input  logic          flag_clr,
    output logic          wr_en,
    output logic [RW-1:0] wr_reg,
    output logic [DW-1:0] wr_data,
    output logic          busy,
    output logic          done,
    output logic [4:0]    count,
    output logic          ovf,
    output logic          udf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [4:0] FULL = 5'(DEPTH);

    state_t state, nstate;

    logic [AW-1:0]    tp;
    logic [4:0]       remaining;
    logic [RW+DW-1:0] rdata;
    logic             push_acc;
    logic             pop;
    logic             underflow;
    logic             full;

    assign full      = (count == FULL);
    assign push_acc  = push_valid && (state == ST_IDLE);
    assign pop       = (state == ST_UNWIND) && (remaining != 5'd0)
                       && (count != 5'd0);
    assign underflow = (state == ST_UNWIND) && (remaining != 5'd0)
                       && (count == 5'd0);

    // when full, tp points at the oldest entry so it is overwritten
    undo_lifo_mem #(
        .DEPTH (DEPTH),
        .W     (RW + DW)
    ) u_mem (
        .clk   (clk),
        .we    (push_acc),
        .waddr (tp),
        .wdata ({push_reg, push_data}),
        .raddr (tp - AW'(1)),
        .rdata (rdata)
    );

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= nstate;
    end

    // next-state decode
    always_comb begin
        nstate = state;
        unique case (state)
            ST_IDLE: begin
                if (unwind_req)
                    nstate = (unwind_n != 5'd0) ? ST_UNWIND : ST_DONE;
            end
            ST_UNWIND: begin
                if (underflow || remaining == 5'd0)
                    nstate = ST_DONE;
                else if (pop && remaining == 5'd1)
                    nstate = ST_DONE;
            end
            ST_DONE: nstate = ST_IDLE;
            default: nstate = ST_IDLE;
        endcase
    end

    // state-decoded outputs
    always_comb begin
        push_ready = (state == ST_IDLE);
        busy       = (state == ST_UNWIND) || (state == ST_DONE);
    end

    // pointers, counters and the registered restore port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tp        <= '0;
            count     <= '0;
            remaining <= '0;
            wr_en     <= 1'b0;
            wr_reg    <= '0;
            wr_data   <= '0;
            done      <= 1'b0;
        end else begin
            if (push_acc) begin
                tp <= tp + AW'(1);
                if (!full) count <= count + 5'd1;
            end
            if (state == ST_IDLE && unwind_req)
                remaining <= unwind_n;
            if (pop) begin
                tp        <= tp - AW'(1);
                count     <= count - 5'd1;
                remaining <= remaining - 5'd1;
                wr_reg    <= rdata[RW+DW-1:DW];
                wr_data   <= rdata[DW-1:0];
            end
            wr_en <= pop;
            done  <= (state == ST_DONE);
        end
    end

    // sticky flags; a new event beats a clear on the same edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (push_acc && full) ovf <= 1'b1;
            else if (flag_clr)    ovf <= 1'b0;
            if (underflow)        udf <= 1'b1;
            else if (flag_clr)    udf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_undo_stack_ctrl.sv
// Directed self-checking bench for undo_stack_ctrl.
// Expected values are hand-computed per step.
module tb_undo_stack_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        push_valid;
    logic [3:0]  push_reg;
    logic [15:0] push_data;
    logic        push_ready;
    logic        unwind_req;
    logic [4:0]  unwind_n;
    logic        flag_clr;
    logic        wr_en;
    logic [3:0]  wr_reg;
    logic [15:0] wr_data;
    logic        busy;
    logic        done;
    logic [4:0]  count;
    logic        ovf;
    logic        udf;

    int n_cmp = 0;
    int n_bad = 0;

    undo_stack_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .push_valid (push_valid),
        .push_reg   (push_reg),
        .push_data  (push_data),
        .push_ready (push_ready),
        .unwind_req (unwind_req),
        .unwind_n   (unwind_n),
        .flag_clr   (flag_clr),
        .wr_en      (wr_en),
        .wr_reg     (wr_reg),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .count      (count),
        .ovf        (ovf),
        .udf        (udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] r, input logic [15:0] d);
        push_valid = 1'b1;
        push_reg   = r;
        push_data  = d;
        tick();
        push_valid = 1'b0;
    endtask

    task automatic unwind(input logic [4:0] n);
        unwind_req = 1'b1;
        unwind_n   = n;
        tick();
        unwind_req = 1'b0;
        unwind_n   = 5'd0;
    endtask

    task automatic clr_flags();
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        push_valid = 1'b0;
        push_reg   = '0;
        push_data  = '0;
        unwind_req = 1'b0;
        unwind_n   = '0;
        flag_clr   = 1'b0;
        tick();
        tick();
        chk("rst_wr_en", wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        chk("rst_flags", {ovf, udf}, 0);
        reset = 1'b0;
        tick();
        chk("rst_ready", push_ready, 1);

        // two pushes, unwind two
        push(4'd3, 16'h1111);
        push(4'd5, 16'h2222);
        chk("t1_count", count, 2);
        unwind(5'd2);
        chk("t1_e0_busy", busy, 1);
        chk("t1_e0_wr", wr_en, 0);
        chk("t1_e0_ready", push_ready, 0);
        tick();
        chk("t1_e1_wr", {wr_en, wr_reg, wr_data}, {1'b1, 4'd5, 16'h2222});
        tick();
        chk("t1_e2_wr", {wr_en, wr_reg, wr_data}, {1'b1, 4'd3, 16'h1111});
        chk("t1_e2_done", done, 0);
        chk("t1_e2_count", count, 0);
        tick();
        chk("t1_e3_wr", wr_en, 0);
        chk("t1_e3_done", done, 1);
        chk("t1_e3_busy", busy, 0);
        tick();
        chk("t1_e4_done", done, 0);

        // overflow: 17 pushes, unwind 16
        for (int i = 0; i < 17; i++)
            push(4'(i), 16'(i));
        chk("t2_ovf", ovf, 1);
        chk("t2_count", count, 16);
        unwind(5'd16);
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("t2_wr%0d", k), {wr_en, wr_reg, wr_data},
                {1'b1, 4'(17 - k), 16'(17 - k)});
        end
        chk("t2_count0", count, 0);
        tick();
        chk("t2_done", done, 1);
        chk("t2_udf", udf, 0);
        clr_flags();
        chk("t2_ovf_clr", ovf, 0);

        // underflow: 2 pushes, unwind 5
        push(4'd7, 16'h000A);
        push(4'd8, 16'h000B);
        unwind(5'd5);
        tick();
        chk("t3_e1_wr", {wr_en, wr_reg, wr_data}, {1'b1, 4'd8, 16'h000B});
        tick();
        chk("t3_e2_wr", {wr_en, wr_reg, wr_data}, {1'b1, 4'd7, 16'h000A});
        tick();
        chk("t3_e3_wr", wr_en, 0);
        chk("t3_e3_udf", udf, 1);
        chk("t3_e3_busy", busy, 1);
        chk("t3_e3_done", done, 0);
        tick();
        chk("t3_e4_done", done, 1);
        chk("t3_count", count, 0);
        clr_flags();
        chk("t3_udf_clr", udf, 0);

        // push and unwind on the same edge
        push_valid = 1'b1;
        push_reg   = 4'd1;
        push_data  = 16'hABCD;
        unwind(5'd1);
        push_valid = 1'b0;
        chk("t4_e0_count", count, 1);
        tick();
        chk("t4_e1_wr", {wr_en, wr_reg, wr_data}, {1'b1, 4'd1, 16'hABCD});
        chk("t4_e1_count", count, 0);
        tick();
        chk("t4_e2_done", done, 1);

        // zero-length unwind, push while busy is refused
        unwind(5'd0);
        push_valid = 1'b1;
        push_reg   = 4'd9;
        push_data  = 16'h9999;
        chk("t5_busy", busy, 1);
        chk("t5_ready", push_ready, 0);
        chk("t5_wr", wr_en, 0);
        tick();
        push_valid = 1'b0;
        chk("t5_done", done, 1);
        chk("t5_idle", busy, 0);
        chk("t5_count", count, 0);
        tick();
        chk("t5_done_off", done, 0);

        // reset in the middle of a 4-entry unwind
        push(4'd2, 16'h0002);
        push(4'd4, 16'h0004);
        push(4'd6, 16'h0006);
        push(4'd8, 16'h0008);
        unwind(5'd4);
        tick();
        chk("t6_e1_wr", {wr_en, wr_data}, {1'b1, 16'h0008});
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_out", {wr_en, busy, done, wr_reg, wr_data},
            {3'b000, 4'd0, 16'd0});
        chk("t6_rst_count", count, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("t6_ready", push_ready, 1);
        chk("t6_done_a", done, 0);
        tick();
        chk("t6_done_b", {done, busy, count}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
